// File: rtl/sample_frame_loader.sv
// Loads one frame of samples from a valid/ready byte stream into an internal RAM.
// It then replays the frame one sample per enabled clock to the rank-order filter input.
module sample_frame_loader #(
    parameter int data_bits = 8,
    parameter int addr_bits = 8,
    parameter int FRAME_LEN = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [data_bits-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 out_en,
    output logic [data_bits-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [addr_bits:0]   fill_count,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } state_t;

    localparam logic [addr_bits-1:0] LAST_ADDR = addr_bits'(FRAME_LEN - 1);
    localparam logic [addr_bits-1:0] ADDR_ONE  = addr_bits'(1);
    localparam logic [addr_bits:0]   FILL_ONE  = (addr_bits + 1)'(1);

    logic [data_bits-1:0] mem [2**addr_bits];

    state_t               state_q, state_d;
    logic [addr_bits-1:0] wr_addr_q, wr_addr_d;
    logic [addr_bits-1:0] rd_addr_q, rd_addr_d;
    logic [addr_bits:0]   fill_count_q, fill_count_d;
    logic [data_bits-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 wr_en;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        fill_count_d = fill_count_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    wr_addr_d    = '0;
                    rd_addr_d    = '0;
                    fill_count_d = '0;
                end
            end
            ST_LOAD: begin
                // in_ready is high for the whole of LOAD, so in_valid alone completes the handshake.
                if (in_valid) begin
                    wr_en        = 1'b1;
                    wr_addr_d    = wr_addr_q + ADDR_ONE;
                    fill_count_d = fill_count_q + FILL_ONE;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (out_en) begin
                    rd_addr_d   = rd_addr_q + ADDR_ONE;
                    out_valid_d = 1'b1;
                    out_data_d  = mem[rd_addr_q];
                    if (rd_addr_q == LAST_ADDR) begin
                        out_last_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the RAM has no reset, so its contents survive a reset; that also lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_addr_q] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            fill_count_q <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            fill_count_q <= fill_count_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_STREAM);
    assign done       = (state_q == ST_DONE);
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign fill_count = fill_count_q;

endmodule

// File: tb/tb_sample_frame_loader.sv
// Scoreboard bench for sample_frame_loader: a frame-level model predicts each replayed sample,
// and a negedge monitor compares whatever the DUT presents.
module tb_sample_frame_loader;

    localparam int DB = 8;
    localparam int AB = 2;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, out_en, out_valid, out_last, busy, done;
    logic [DB-1:0] in_data, out_data;
    logic [AB:0]   fill_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DB-1:0] data;
        logic          last;
    } exp_t;

    typedef enum {M_IDLE, M_LOAD, M_STREAM, M_DONE} mphase_t;

    exp_t          sb_q[$];
    mphase_t       m_phase = M_IDLE;
    logic [DB-1:0] m_frame[$];
    int            m_rd = 0;
    int            m_fill = 0;

    exp_t          mon_e;
    logic [DB-1:0] mon_last = '0;
    bit            mon_hold_en = 1'b0;

    sample_frame_loader #(.data_bits(DB), .addr_bits(AB), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_en    (out_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .fill_count(fill_count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances by the frame rules and predicts the status outputs.
    task automatic cycle(input logic r, input logic s, input logic iv, input logic [DB-1:0] d,
                         input logic oe);
        exp_t e;
        bit   push;
        rst = r; start = s; in_valid = iv; in_data = d; out_en = oe;
        push = 1'b0;
        e.data = '0;
        e.last = 1'b0;
        if (!r) begin
            m_phase = M_IDLE;
            m_fill  = 0;
            m_rd    = 0;
            m_frame.delete();
        end else begin
            case (m_phase)
                M_IDLE, M_DONE: if (s) begin
                    m_phase = M_LOAD;
                    m_fill  = 0;
                    m_rd    = 0;
                    m_frame.delete();
                end
                M_LOAD: if (iv) begin
                    m_frame.push_back(d);
                    m_fill++;
                    if (m_frame.size() == FL) m_phase = M_STREAM;
                end
                M_STREAM: if (oe) begin
                    e.data = m_frame[m_rd];
                    e.last = (m_rd == FL - 1);
                    push   = 1'b1;
                    m_rd++;
                    if (m_rd == FL) m_phase = M_DONE;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        if (push) sb_q.push_back(e);
        check("in_ready", in_ready, m_phase == M_LOAD);
        check("busy", busy, (m_phase == M_LOAD) || (m_phase == M_STREAM));
        check("done", done, m_phase == M_DONE);
        check("fill_count", fill_count, m_fill);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic load_frame(input logic [DB-1:0] a, input logic [DB-1:0] b,
                              input logic [DB-1:0] c, input logic [DB-1:0] d);
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, a, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, b, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, c, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic check_drained(input string name);
        idle(2);
        check(name, sb_q.size(), 0);
    endtask

    // Monitor: any expected sample or any DUT valid is compared; idle cycles check out_data holds.
    always @(negedge clk) begin
        if (sb_q.size() > 0 || out_valid === 1'b1) begin
            check("out_valid", out_valid, 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_last", out_last, mon_e.last);
                mon_last = mon_e.data;
            end
        end else if (mon_hold_en) begin
            check("out_data_hold", out_data, mon_last);
        end
        if (rst === 1'b0) begin
            mon_last    = '0;
            mon_hold_en = 1'b1;
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_en = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        idle(1);

        // Continuous load of 10,20,30,40 and full-rate replay.
        load_frame(8'd10, 8'd20, 8'd30, 8'd40);
        check("t1_fill", fill_count, 4);
        for (int i = 0; i < FL; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_drained("t1_drain");

        // Gapped input, then a stalled replay pattern 1,0,0,1,1,1.
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 2 * FL; i++)
            cycle(1'b1, 1'b0, (i % 2) == 0, 8'(100 + i), 1'b0);
        begin
            logic [5:0] pat;
            pat = 6'b111001;
            for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, '0, pat[i]);
        end
        check_drained("t3_drain");

        // in_valid held after the frame is full; junk must not reach the RAM.
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < FL; i++) cycle(1'b1, 1'b0, 1'b1, 8'(i + 1), 1'b0);
        for (int i = 0; i < FL + 2; i++) cycle(1'b1, 1'b0, 1'b1, 8'hEE, (i % 3) != 1);
        check_drained("t4_drain");

        // One-cycle reset mid-STREAM, then reload.
        load_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("t5_out_valid", out_valid, 0);
        check("t5_out_last", out_last, 0);
        check("t5_out_data", out_data, 0);
        idle(2);
        check("t5_no_tail", sb_q.size(), 0);
        load_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        for (int i = 0; i < FL; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_drained("t5_drain");

        // From DONE: start with in_valid (sample not taken), then 5,6,7,8.
        cycle(1'b1, 1'b1, 1'b1, 8'd99, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'd6, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'd7, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'd8, 1'b0);
        for (int i = 0; i < FL; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_drained("t6_drain");

        // start and rst together: reset wins.
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("rst_vs_start_busy", busy, 0);
        idle(1);

        // Random traffic: stray starts, gapped input, stalled replay, rare resets.
        for (int i = 0; i < 1500; i++) begin
            logic r, s;
            r = ($urandom_range(0, 99) != 0);
            s = (m_phase == M_IDLE || m_phase == M_DONE) ? ($urandom_range(0, 1) == 1)
                                                         : ($urandom_range(0, 7) == 0);
            cycle(r, s, $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        end
        check_drained("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
